// File: rtl/asg_burst_gen.sv
`default_nettype none
// ============================================================================
// Module   : asg_burst_gen
// Function : triggered table sample generator, burst framing, optional linear
//            interpolation, stream output with backpressure
// Revision : 1.0 - initial release
// ============================================================================
module asg_burst_gen #(
   parameter int DW     = 14,
   parameter int CWM    = 14,
   parameter int CWF    = 16,
   parameter int EN_INT = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 ctl_rst,
   input  logic                 ctl_str,
   input  logic                 trg_i,
   input  logic [CWM+CWF-1:0]   cfg_siz,
   input  logic [CWM+CWF-1:0]   cfg_off,
   input  logic [CWM+CWF-1:0]   cfg_stp,
   input  logic                 cfg_ben,
   input  logic [CWM-1:0]       cfg_bdl,
   input  logic [31:0]          cfg_bln,
   input  logic [15:0]          cfg_bnm,
   input  logic                 cfg_binf,
   input  logic                 cfg_int,
   input  logic                 buf_we,
   input  logic [CWM-1:0]       buf_wa,
   input  logic [DW-1:0]        buf_wd,
   output logic [DW-1:0]        sto_tdata,
   output logic                 sto_tvalid,
   input  logic                 sto_tready,
   output logic                 sto_tlast,
   output logic                 sts_run,
   output logic                 irq_trg,
   output logic                 irq_stp
);
   localparam int PW  = CWM + CWF;
   localparam int PW1 = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_run, r_irq_trg, r_irq_stp, r_done;
   logic [PW-1:0]    r_ptr;
   logic [31:0]      r_cnt;
   logic [15:0]      r_per;
   logic             r_s1_vld, r_s1_dat, r_s1_last;
   logic [CWM-1:0]   r_s1_idx, r_s1_nxt;
   logic [7:0]       r_s1_frac;
   logic             r_s2_vld, r_s2_dat, r_s2_last;
   logic [7:0]       r_s2_frac;
   logic [DW-1:0]    r_rd_a, r_rd_b;
   logic [DW-1:0]    r_mem [0:(1<<CWM)-1];
   logic             r_tvalid, r_tlast;
   logic [DW-1:0]    r_tdata;

   logic             w_en, w_issue, w_wrap, w_bdat, w_bend, w_blast, w_accept_last;
   logic [PW1-1:0]   w_sum;
   logic [PW-1:0]    w_ptr_nxt;
   logic [CWM-1:0]   w_idx, w_nxt;
   logic [DW-1:0]    w_smp;

   assign w_en          = !r_tvalid || sto_tready;
   assign w_issue       = (r_state == S_RUN) && !r_done;
   assign w_sum         = {1'b0, r_ptr} + {1'b0, cfg_stp} + PW1'(1);
   assign w_wrap        = w_sum > {1'b0, cfg_siz};
   assign w_ptr_nxt     = w_wrap ? PW'(w_sum - {1'b0, cfg_siz} - PW1'(1)) : w_sum[PW-1:0];
   assign w_idx         = r_ptr[PW-1:CWF];
   assign w_nxt         = (w_idx == cfg_siz[PW-1:CWF]) ? '0 : w_idx + CWM'(1);
   assign w_bend        = cfg_ben && (r_cnt == cfg_bln);
   assign w_bdat        = !cfg_ben || (r_cnt <= {{(32-CWM){1'b0}}, cfg_bdl});
   assign w_blast       = w_bend && !cfg_binf && (r_per == cfg_bnm);
   assign w_accept_last = r_tvalid && sto_tready && r_tlast;

   // Control FSM plus the address stage; the pointer moves as samples enter the pipe
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_run     <= 1'b0;
         r_irq_trg <= 1'b0;
         r_irq_stp <= 1'b0;
         r_done    <= 1'b0;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_per     <= '0;
         r_s1_vld  <= 1'b0;
         r_s1_dat  <= 1'b0;
         r_s1_last <= 1'b0;
         r_s1_idx  <= '0;
         r_s1_nxt  <= '0;
         r_s1_frac <= '0;
      end else begin
         r_irq_trg <= 1'b0;
         r_irq_stp <= 1'b0;
         if (ctl_rst) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_per     <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (ctl_str) r_state <= S_ARMED;
               end
               S_ARMED: begin
                  if (trg_i) begin
                     r_state   <= S_RUN;
                     r_run     <= 1'b1;
                     r_irq_trg <= 1'b1;
                     r_ptr     <= cfg_off;
                     r_cnt     <= '0;
                     r_per     <= '0;
                     r_done    <= 1'b0;
                  end
               end
               S_RUN: begin
                  if (w_accept_last) begin
                     r_state   <= S_IDLE;
                     r_run     <= 1'b0;
                     r_irq_stp <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
            if (w_en) begin
               r_s1_vld  <= w_issue;
               r_s1_idx  <= w_idx;
               r_s1_nxt  <= w_nxt;
               r_s1_frac <= r_ptr[CWF-1:CWF-8];
               r_s1_dat  <= w_bdat;
               r_s1_last <= w_blast;
               if (w_issue) begin
                  if (w_bend) begin
                     r_cnt  <= '0;
                     r_per  <= r_per + 16'd1;
                     r_ptr  <= cfg_off;
                     r_done <= w_blast;
                  end else begin
                     r_cnt  <= r_cnt + 32'd1;
                     r_ptr  <= w_ptr_nxt;
                  end
               end
            end
         end
      end
   end

   // Table RAM: read-before-write, contents survive reset
   always_ff @(posedge clk) begin
      if (buf_we) r_mem[buf_wa] <= buf_wd;
      if (w_en) begin
         r_rd_a <= r_mem[r_s1_idx];
         r_rd_b <= r_mem[r_s1_nxt];
      end
   end

   generate
      if (EN_INT != 0) begin : g_int
         logic signed [DW:0]   w_diff;
         logic signed [DW+9:0] w_dx, w_fx, w_prod, w_shf, w_ax, w_res;
         logic                 w_unused;
         assign w_diff   = $signed({r_rd_b[DW-1], r_rd_b}) - $signed({r_rd_a[DW-1], r_rd_a});
         assign w_dx     = {{9{w_diff[DW]}}, w_diff};
         assign w_fx     = {{(DW+2){1'b0}}, r_s2_frac};
         assign w_prod   = w_dx * w_fx;
         assign w_shf    = w_prod >>> 8;
         assign w_ax     = {{10{r_rd_a[DW-1]}}, r_rd_a};
         assign w_res    = w_ax + w_shf;
         assign w_smp    = cfg_int ? w_res[DW-1:0] : r_rd_a;
         assign w_unused = ^w_res[DW+9:DW];
      end else begin : g_noint
         logic w_unused;
         assign w_smp    = r_rd_a;
         assign w_unused = ^{cfg_int, r_rd_b, r_s2_frac};
      end
   endgenerate

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_s2_vld  <= 1'b0;
         r_s2_dat  <= 1'b0;
         r_s2_last <= 1'b0;
         r_s2_frac <= '0;
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
         r_tdata   <= '0;
      end else if (ctl_rst) begin
         r_s2_vld  <= 1'b0;
         r_tvalid  <= 1'b0;
         r_tlast   <= 1'b0;
      end else if (w_en) begin
         r_s2_vld  <= r_s1_vld;
         r_s2_dat  <= r_s1_dat;
         r_s2_last <= r_s1_last;
         r_s2_frac <= r_s1_frac;
         r_tvalid  <= r_s2_vld;
         r_tlast   <= r_s2_vld && r_s2_last;
         r_tdata   <= r_s2_dat ? w_smp : '0;
      end
   end

   assign sto_tdata  = r_tdata;
   assign sto_tvalid = r_tvalid;
   assign sto_tlast  = r_tlast;
   assign sts_run    = r_run;
   assign irq_trg    = r_irq_trg;
   assign irq_stp    = r_irq_stp;

endmodule
`default_nettype wire
